// File: rtl/writeback_regfile_if.sv
// Bundle of MEM/WB inputs, decode read ports and committed-write outputs for writeback_regfile.
// The instret signal exists only when WB_INSTRET_EN is defined.
interface writeback_regfile_if;
    logic [31:0] mem_read_data;
    logic [31:0] alu_out;
    logic [4:0]  rd;
    logic [7:0]  control_unit_signal;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    modport master (
`ifdef WB_INSTRET_EN
        input  instret,
`endif
        output mem_read_data,
        output alu_out,
        output rd,
        output control_unit_signal,
        output rs1_addr,
        output rs2_addr,
        input  rs1_data,
        input  rs2_data,
        input  wb_en,
        input  wb_rd,
        input  wb_data
    );

    modport slave (
`ifdef WB_INSTRET_EN
        output instret,
`endif
        input  mem_read_data,
        input  alu_out,
        input  rd,
        input  control_unit_signal,
        input  rs1_addr,
        input  rs2_addr,
        output rs1_data,
        output rs2_data,
        output wb_en,
        output wb_rd,
        output wb_data
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage with load formatting and a 31-entry register file with write-through bypass.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_regfile (
    input  logic               clk,
    input  logic               rst,
    writeback_regfile_if.slave bus
);
    logic        reg_write;
    logic        mem_to_reg;
    logic        valid;
    logic [2:0]  funct3;
    logic        unused_ctrl;

    assign reg_write   = bus.control_unit_signal[0];
    assign mem_to_reg  = bus.control_unit_signal[1];
    assign funct3      = bus.control_unit_signal[4:2];
    assign valid       = bus.control_unit_signal[5];
    assign unused_ctrl = ^bus.control_unit_signal[7:6];

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] wb_data;
    logic        wb_en;

    // Halfword selection uses only alu_out[1]; misaligned halves are silently realigned.
    always_comb begin
        load_byte = bus.mem_read_data[7:0];
        case (bus.alu_out[1:0])
            2'd0: load_byte = bus.mem_read_data[7:0];
            2'd1: load_byte = bus.mem_read_data[15:8];
            2'd2: load_byte = bus.mem_read_data[23:16];
            2'd3: load_byte = bus.mem_read_data[31:24];
            default: load_byte = bus.mem_read_data[7:0];
        endcase
        load_half = bus.alu_out[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    end

    always_comb begin
        load_data = bus.mem_read_data;
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = bus.mem_read_data;
        endcase
    end

    assign wb_data     = mem_to_reg ? load_data : bus.alu_out;
    assign wb_en       = valid & reg_write & (bus.rd != 5'd0);
    assign bus.wb_en   = wb_en;
    assign bus.wb_rd   = bus.rd;
    assign bus.wb_data = wb_data;

    // x0 has no storage; entries 1..31 only.
    logic [31:0] regs [1:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            for (int i = 1; i < 32; i++) begin
                if (bus.rd == 5'(i)) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    logic [31:0] rs1_stored;
    logic [31:0] rs2_stored;

    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        for (int i = 1; i < 32; i++) begin
            if (bus.rs1_addr == 5'(i)) begin
                rs1_stored = regs[i];
            end
            if (bus.rs2_addr == 5'(i)) begin
                rs2_stored = regs[i];
            end
        end
    end

    // Bypass lets decode see this cycle's commit before it lands in storage.
    always_comb begin
        if (bus.rs1_addr == 5'd0) begin
            bus.rs1_data = '0;
        end else if (wb_en && (bus.rs1_addr == bus.rd)) begin
            bus.rs1_data = wb_data;
        end else begin
            bus.rs1_data = rs1_stored;
        end

        if (bus.rs2_addr == 5'd0) begin
            bus.rs2_data = '0;
        end else if (wb_en && (bus.rs2_addr == bus.rd)) begin
            bus.rs2_data = wb_data;
        end else begin
            bus.rs2_data = rs2_stored;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_count <= '0;
        end else if (valid) begin
            instret_count <= instret_count + 64'd1;
        end
    end

    assign bus.instret = instret_count;
`endif
endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: expectations queued at stimulus, checked mid-cycle.
// Counter checks are included only when WB_INSTRET_EN is defined.
module tb_writeback_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    writeback_regfile_if bus();

    writeback_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int SEL_WB_EN   = 0;
    localparam int SEL_WB_RD   = 1;
    localparam int SEL_WB_DATA = 2;
    localparam int SEL_RS1     = 3;
    localparam int SEL_RS2     = 4;
    localparam int SEL_INSTRET = 5;

    typedef struct {
        int          sel;
        string       tag;
        logic [63:0] value;
    } exp_t;

    exp_t        exp_q[$];
    int          tests    = 0;
    int          failures = 0;
    logic [31:0] model_regs [32];
    logic [63:0] instret_model = '0;
    logic        pend_en    = 1'b0;
    logic        pend_valid = 1'b0;
    logic [4:0]  pend_rd    = '0;
    logic [31:0] pend_data  = '0;

    function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return 32'(b);
            3'b001:  return 32'($signed(h));
            3'b101:  return 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (addr == 5'd0) return '0;
        if (pend_en && addr == pend_rd) return pend_data;
        return model_regs[addr];
    endfunction

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_WB_EN:   return 64'(bus.wb_en);
            SEL_WB_RD:   return 64'(bus.wb_rd);
            SEL_WB_DATA: return 64'(bus.wb_data);
            SEL_RS1:     return 64'(bus.rs1_data);
            SEL_RS2:     return 64'(bus.rs2_data);
`ifdef WB_INSTRET_EN
            SEL_INSTRET: return bus.instret;
`endif
            default:     return '0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpect(input int sel, input string tag, input logic [63:0] value);
        exp_t e;
        e.sel   = sel;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic checkResults();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, observe(e.sel), e.value);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic rw, input logic m2r,
                                 input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [4:0] a1, input logic [4:0] a2);
        bus.control_unit_signal = {2'b00, v, f3, m2r, rw};
        bus.rd            = rd;
        bus.alu_out       = alu;
        bus.mem_read_data = mem;
        bus.rs1_addr      = a1;
        bus.rs2_addr      = a2;
        pend_valid = v;
        pend_en    = v && rw && (rd != 5'd0);
        pend_rd    = rd;
        pend_data  = m2r ? fmt_load(mem, alu[1:0], f3) : alu;
        pushExpect(SEL_WB_EN,   {tag, "_wb_en"},   64'(pend_en));
        pushExpect(SEL_WB_RD,   {tag, "_wb_rd"},   64'(rd));
        pushExpect(SEL_WB_DATA, {tag, "_wb_data"}, 64'(pend_data));
        pushExpect(SEL_RS1,     {tag, "_rs1"},     64'(model_read(a1)));
        pushExpect(SEL_RS2,     {tag, "_rs2"},     64'(model_read(a2)));
`ifdef WB_INSTRET_EN
        pushExpect(SEL_INSTRET, {tag, "_instret"}, instret_model);
`endif
    endtask

    // Check at the falling edge, then retire the pending write into the model at the rising edge.
    task automatic stepCycle();
        @(negedge clk);
        checkResults();
        @(posedge clk);
        if (!rst) begin
            if (pend_en) model_regs[pend_rd] = pend_data;
            if (pend_valid) instret_model = instret_model + 64'd1;
        end
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        instret_model = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clearModel();
        bus.control_unit_signal = '0;
        bus.rd            = '0;
        bus.alu_out       = '0;
        bus.mem_read_data = '0;
        bus.rs1_addr      = '0;
        bus.rs2_addr      = '0;

        @(posedge clk);
        #1;
        applyStimulus("in_reset", 1'b0, 1'b0, 1'b0, 3'b010, 5'd1, 32'h0, 32'h0, 5'd1, 5'd2);
        stepCycle();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            applyStimulus("reset_state", 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            stepCycle();
        end

        applyStimulus("lb", 1'b1, 1'b1, 1'b1, 3'b000, 5'd7, 32'h0000_0003, 32'h80FF_7F01, 5'd7, 5'd0);
        pushExpect(SEL_WB_DATA, "lb_literal", 64'h0000_0000_FFFF_FF80);
        stepCycle();
        applyStimulus("lbu", 1'b1, 1'b1, 1'b1, 3'b100, 5'd7, 32'h0000_0003, 32'h80FF_7F01, 5'd7, 5'd7);
        pushExpect(SEL_WB_DATA, "lbu_literal", 64'h0000_0000_0000_0080);
        stepCycle();
        applyStimulus("lh", 1'b1, 1'b1, 1'b1, 3'b001, 5'd7, 32'h0000_0002, 32'h80FF_7F01, 5'd7, 5'd0);
        pushExpect(SEL_WB_DATA, "lh_literal", 64'h0000_0000_FFFF_80FF);
        stepCycle();
        applyStimulus("lhu", 1'b1, 1'b1, 1'b1, 3'b101, 5'd7, 32'h0000_0002, 32'h80FF_7F01, 5'd7, 5'd0);
        pushExpect(SEL_WB_DATA, "lhu_literal", 64'h0000_0000_0000_80FF);
        stepCycle();
        applyStimulus("lh_misaligned", 1'b1, 1'b1, 1'b1, 3'b001, 5'd8, 32'h0000_0003, 32'h80FF_7F01, 5'd7, 5'd8);
        pushExpect(SEL_WB_DATA, "lh_misaligned_literal", 64'h0000_0000_FFFF_80FF);
        stepCycle();
        applyStimulus("lw_code011", 1'b1, 1'b1, 1'b1, 3'b011, 5'd10, 32'h0000_0001, 32'h80FF_7F01, 5'd8, 5'd10);
        pushExpect(SEL_WB_DATA, "lw_code011_literal", 64'h0000_0000_80FF_7F01);
        stepCycle();

        applyStimulus("x0_write", 1'b1, 1'b1, 1'b0, 3'b010, 5'd0, 32'h1234_5678, 32'h0, 5'd0, 5'd0);
        pushExpect(SEL_WB_EN, "x0_wb_en_literal", 64'd0);
        pushExpect(SEL_RS1, "x0_before_literal", 64'd0);
        stepCycle();
        applyStimulus("x0_after", 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 32'h0, 5'd0, 5'd10);
        pushExpect(SEL_RS1, "x0_after_literal", 64'd0);
        stepCycle();

        applyStimulus("bypass", 1'b1, 1'b1, 1'b0, 3'b010, 5'd9, 32'hA5A5_A5A5, 32'h0, 5'd9, 5'd9);
        pushExpect(SEL_RS1, "bypass_rs1_literal", 64'h0000_0000_A5A5_A5A5);
        pushExpect(SEL_RS2, "bypass_rs2_literal", 64'h0000_0000_A5A5_A5A5);
        stepCycle();
        applyStimulus("stored", 1'b0, 1'b1, 1'b0, 3'b010, 5'd9, 32'h0, 32'h0, 5'd9, 5'd9);
        pushExpect(SEL_RS1, "stored_rs1_literal", 64'h0000_0000_A5A5_A5A5);
        stepCycle();

        for (int n = 0; n < 150; n++) begin
            logic [4:0] r;
            logic [4:0] a1;
            logic [4:0] a2;
            r  = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31));
            applyStimulus("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r,
                          $urandom, $urandom, a1, a2);
            stepCycle();
        end

        applyStimulus("x5_write", 1'b1, 1'b1, 1'b0, 3'b010, 5'd5, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd0);
        stepCycle();
        applyStimulus("x5_read", 1'b0, 1'b0, 1'b0, 3'b010, 5'd5, 32'h0, 32'h0, 5'd5, 5'd5);
        pushExpect(SEL_RS1, "x5_read_literal", 64'h0000_0000_DEAD_BEEF);
        stepCycle();
        #2;
        rst = 1'b1;
        clearModel();
        #1;
        pushExpect(SEL_RS1, "async_reset_clear", 64'd0);
        checkResults();
        applyStimulus("reset_bypass", 1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'h1111_2222, 32'h0, 5'd3, 5'd4);
        pushExpect(SEL_RS1, "reset_bypass_literal", 64'h0000_0000_1111_2222);
        stepCycle();
        rst = 1'b0;
        applyStimulus("after_reset", 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 32'h0, 5'd3, 5'd5);
        pushExpect(SEL_RS1, "discarded_write_literal", 64'd0);
        stepCycle();

        doReset();
        for (int n = 0; n < 10; n++) begin
            applyStimulus("count", 1'b1, !(n == 2 || n == 5 || n == 8), 1'b0, 3'b010,
                          5'(n + 11), 32'(n), 32'h0, 5'(n + 11), 5'd0);
            stepCycle();
        end
        for (int n = 0; n < 4; n++) begin
            applyStimulus("idle", 1'b0, 1'b1, 1'b0, 3'b010, 5'd12, 32'hFFFF_FFFF, 32'h0, 5'd12, 5'd13);
            stepCycle();
        end
        applyStimulus("count_done", 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 32'h0, 5'd11, 5'd13);
`ifdef WB_INSTRET_EN
        pushExpect(SEL_INSTRET, "instret_literal", 64'd10);
`endif
        stepCycle();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port mem_read_data, input, 32, raw word from the MEM/WB stage.
REQ-004 SHALL have port alu_out, input, 32, ALU result from MEM/WB; bits [1:0] are the load byte offset.
REQ-005 SHALL have port rd, input, 5, destination register index.
REQ-006 SHALL have port control_unit_signal, input, 8, [0] reg_write, [1] mem_to_reg, [4:2] load funct3, [5] valid, [7:6] ignored.
REQ-007 SHALL have ports rs1_addr and rs2_addr, input, 5 each, decode-stage read addresses.
REQ-008 SHALL have ports rs1_data and rs2_data, output, 32 each, read data.
REQ-009 SHALL have port wb_en, output, 1, a write is being committed this cycle.
REQ-010 SHALL have port wb_rd, output, 5, destination of the committed write.
REQ-011 SHALL have port wb_data, output, 32, formatted write data, for forwarding.
REQ-012 SHALL have port instret, output, 64, retired-instruction count; present only when WB_INSTRET_EN is defined.

Function
REQ-013 SHALL contain 31 x 32-bit registers x1..x31; x0 SHALL read as 0 and never be stored.
REQ-014 wb_en SHALL equal valid AND reg_write AND (rd != 0), combinationally.
REQ-015 wb_rd SHALL equal rd; wb_data SHALL equal the formatted load data when mem_to_reg=1, else alu_out.
REQ-016 Load formatting by funct3, using offset = alu_out[1:0]: 000 sign-extended byte at offset*8; 100 zero-extended byte at offset*8; 001 sign-extended half at alu_out[1]*16; 101 zero-extended half at alu_out[1]*16; 010 and all other codes full word.
REQ-017 Halfword formatting SHALL ignore alu_out[0] (misaligned access is not trapped).
REQ-018 On a rising clk edge with wb_en=1, register[rd] SHALL take wb_data; with wb_en=0, no register changes.
REQ-019 Read ports SHALL be combinational: address 0 -> 0; address == wb_rd with wb_en=1 -> wb_data (write-through bypass); otherwise the stored value.
REQ-020 Both read ports SHALL bypass independently; both addressing the same register SHALL return identical data.
REQ-021 Write latency SHALL be one edge: a value written at edge N SHALL read from storage from edge N onward, and via bypass during the cycle before edge N.

Reset
REQ-022 Asserting rst SHALL clear x1..x31 to 0 immediately, independent of clk.
REQ-023 While rst=1, no write SHALL occur, and instret SHALL be held at 0.
REQ-024 wb_en, wb_rd and wb_data are combinational and SHALL follow the inputs during reset; rs1_data and rs2_data SHALL read 0, except that bypass data SHALL still be returned.
REQ-025 A write whose edge coincides with rst=1 SHALL be discarded.

Configuration
REQ-026 Macro WB_INSTRET_EN: when defined, a 64-bit counter SHALL increment by 1 on each edge where valid=1, and SHALL be driven on instret.
REQ-027 The counter SHALL count valid=1 regardless of reg_write and of rd, and SHALL wrap from 2^64-1 to 0.
REQ-028 When WB_INSTRET_EN is undefined, the instret port and the counter logic SHALL be absent, with no other behaviour change.

Verification
REQ-029 Reset clears: write x5=0xDEADBEEF, then pulse rst mid-cycle -> rs1_addr=5 reads 0x00000000 immediately.
REQ-030 Load byte sign extension: mem_read_data=0x80FF7F01, alu_out[1:0]=3, funct3=000, mem_to_reg=1, rd=7 -> wb_data=0xFFFFFF80; with funct3=100 -> 0x00000080.
REQ-031 Load half: same word, alu_out[1:0]=2, funct3=001 -> wb_data=0xFFFF80FF; with funct3=101 -> 0x000080FF.
REQ-032 x0 protection: valid=1, reg_write=1, rd=0, alu_out=0x12345678 -> wb_en=0, and rs1_addr=0 reads 0 before and after the edge.
REQ-033 Bypass: wb_en=1 with rd=9, data 0xA5A5A5A5, and rs1_addr=rs2_addr=9 in the same cycle -> both ports read 0xA5A5A5A5 before the edge; storage holds it after the edge.
REQ-034 Counter (WB_INSTRET_EN): 10 cycles with valid=1, of which 3 have reg_write=0 -> instret=10; valid=0 cycles leave it unchanged.
